// File: rtl/bcd_clock_pkg.sv
// Shared constants and BCD helpers for the extended BCD wall clock.
package bcd_clock_pkg;

    localparam logic [7:0] BCD_00 = 8'h00;
    localparam logic [7:0] BCD_01 = 8'h01;
    localparam logic [7:0] BCD_11 = 8'h11;
    localparam logic [7:0] BCD_12 = 8'h12;
    localparam logic [7:0] BCD_23 = 8'h23;
    localparam logic [7:0] BCD_59 = 8'h59;

    // Result of a two-digit BCD increment: carry is set on 99 -> 00.
    typedef struct packed {
        logic       carry;
        logic [7:0] value;
    } bcd_inc_t;

    // True when both nibbles hold a decimal digit.
    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Two-digit BCD increment with decimal carry between nibbles.
    function automatic bcd_inc_t bcd_inc(input logic [7:0] v);
        bcd_inc_t r;
        r.carry = 1'b0;
        r.value = v;
        if (v[3:0] == 4'd9) begin
            r.value[3:0] = 4'd0;
            if (v[7:4] == 4'd9) begin
                r.value[7:4] = 4'd0;
                r.carry      = 1'b1;
            end else begin
                r.value[7:4] = v[7:4] + 4'd1;
            end
        end else begin
            r.value[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // Next value of a BCD counter: hold, wrap to 00, or step by one.
    function automatic logic [7:0] bcd_next(input logic [7:0] v,
                                            input logic inc,
                                            input logic wrap);
        bcd_inc_t r;
        r = bcd_inc(v);
        if (!inc)
            return v;
        if (wrap || r.carry)
            return BCD_00;
        return r.value;
    endfunction

endpackage

// File: rtl/bcd_clock_ext_mod60.sv
// Two-digit BCD modulo-60 counter used for both seconds and minutes.
module bcd_mod60
    import bcd_clock_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       ld,
    input  logic [7:0] ld_val,
    input  logic       inc,
    output logic [7:0] q,
    output logic       wrap
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Carry-out to the next stage: this stage rolls 59 -> 00 on this edge.
    assign wrap = (q_q == BCD_59) && inc;
    assign q    = q_q;

    // Next value: clear beats load beats increment.
    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = BCD_00;
        else if (ld)
            q_d = ld_val;
        else
            q_d = bcd_next(q_q, inc, q_q == BCD_59);
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            q_q <= BCD_00;
        else
            q_q <= q_d;
    end

endmodule

// File: rtl/bcd_clock_ext.sv
// BCD wall clock with 12h/24h mode, tick prescaler, checked time-set and alarm.
module bcd_clock_ext
    import bcd_clock_pkg::*;
#(
    parameter int MODE24   = 0,
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ena,
    input  logic       load,
    input  logic [7:0] ld_hh,
    input  logic [7:0] ld_mm,
    input  logic [7:0] ld_ss,
    input  logic       ld_pm,
    input  logic       alarm_en,
    input  logic [7:0] al_hh,
    input  logic [7:0] al_mm,
    input  logic [7:0] al_ss,
    input  logic       al_pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       sec_tick,
    output logic       alarm_hit,
    output logic       ld_err
);

    localparam int               CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0]       HH_RST  = (MODE24 != 0) ? BCD_00 : BCD_12;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       hh_q, hh_d;
    logic             pm_q, pm_d;
    logic             sec_tick_q, alarm_q, ld_err_q;
    logic             alarm_d;

    logic             ld_ok, take_load, tick, adv;
    logic [7:0]       ss_val, mm_val, ss_nx, mm_nx;
    logic             ss_wrap, mm_wrap;

    // A load is legal only with decimal digits and in-range fields.
    always_comb begin
        ld_ok = bcd_valid(ld_hh) && bcd_valid(ld_mm) && bcd_valid(ld_ss) &&
                (ld_mm <= BCD_59) && (ld_ss <= BCD_59);
        if (MODE24 != 0)
            ld_ok = ld_ok && (ld_hh <= BCD_23);
        else
            ld_ok = ld_ok && (ld_hh >= BCD_01) && (ld_hh <= BCD_12);
    end

    // Any load request, accepted or not, swallows that cycle's ena.
    assign take_load = load && ld_ok;
    assign tick      = ena && !load;
    assign adv       = tick && (cnt_q == CNT_MAX);

    // Prescaler: clears on accepted load, rolls over on each second advance.
    always_comb begin
        cnt_d = cnt_q;
        if (take_load)
            cnt_d = '0;
        else if (tick)
            cnt_d = adv ? '0 : cnt_q + CNT_W'(1);
    end

    bcd_mod60 u_sec (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (1'b0),
        .ld      (take_load),
        .ld_val  (ld_ss),
        .inc     (adv),
        .q       (ss_val),
        .wrap    (ss_wrap)
    );

    bcd_mod60 u_min (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (1'b0),
        .ld      (take_load),
        .ld_val  (ld_mm),
        .inc     (ss_wrap),
        .q       (mm_val),
        .wrap    (mm_wrap)
    );

    // Hours and pm: 12,01..11 with pm flip at 11->12, or 00..23 with pm from hour.
    always_comb begin
        hh_d = hh_q;
        pm_d = pm_q;
        if (take_load) begin
            hh_d = ld_hh;
            pm_d = (MODE24 != 0) ? (ld_hh >= BCD_12) : ld_pm;
        end else if (mm_wrap) begin
            if (MODE24 != 0) begin
                hh_d = bcd_next(hh_q, 1'b1, hh_q == BCD_23);
                pm_d = (hh_d >= BCD_12);
            end else if (hh_q == BCD_12) begin
                hh_d = BCD_01;
            end else begin
                hh_d = bcd_next(hh_q, 1'b1, 1'b0);
                if (hh_q == BCD_11)
                    pm_d = ~pm_q;
            end
        end
    end

    // Alarm compares the time that a second advance is about to display.
    always_comb begin
        ss_nx   = bcd_next(ss_val, 1'b1, ss_val == BCD_59);
        mm_nx   = bcd_next(mm_val, ss_val == BCD_59, mm_val == BCD_59);
        alarm_d = adv && alarm_en &&
                  (hh_d == al_hh) && (mm_nx == al_mm) && (ss_nx == al_ss) &&
                  ((MODE24 != 0) || (pm_d == al_pm));
    end

    // State and registered pulse outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            hh_q       <= HH_RST;
            pm_q       <= 1'b0;
            sec_tick_q <= 1'b0;
            alarm_q    <= 1'b0;
            ld_err_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            hh_q       <= hh_d;
            pm_q       <= pm_d;
            sec_tick_q <= adv;
            alarm_q    <= alarm_d;
            ld_err_q   <= load && !ld_ok;
        end
    end

    assign hh        = hh_q;
    assign mm        = mm_val;
    assign ss        = ss_val;
    assign pm        = pm_q;
    assign sec_tick  = sec_tick_q;
    assign alarm_hit = alarm_q;
    assign ld_err    = ld_err_q;

endmodule

// File: tb/tb_bcd_clock_ext.sv
// Randomised bench: a 12h/TICK_DIV=4 and a 24h/TICK_DIV=1 clock against a seconds-of-day model.
module tb_bcd_clock_ext;

    logic       clk = 1'b0;
    logic       reset_n, ena, load, ld_pm, alarm_en, al_pm;
    logic [7:0] ld_hh, ld_mm, ld_ss, al_hh, al_mm, al_ss;

    logic [7:0] hh_a, mm_a, ss_a, hh_b, mm_b, ss_b;
    logic       pm_a, tick_a, hit_a, err_a, pm_b, tick_b, hit_b, err_b;

    always #5 clk = ~clk;

    bcd_clock_ext #(.MODE24(0), .TICK_DIV(4)) u_dut12 (
        .clk(clk), .reset_n(reset_n), .ena(ena), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss), .ld_pm(ld_pm),
        .alarm_en(alarm_en), .al_hh(al_hh), .al_mm(al_mm), .al_ss(al_ss), .al_pm(al_pm),
        .hh(hh_a), .mm(mm_a), .ss(ss_a), .pm(pm_a),
        .sec_tick(tick_a), .alarm_hit(hit_a), .ld_err(err_a)
    );

    bcd_clock_ext #(.MODE24(1), .TICK_DIV(1)) u_dut24 (
        .clk(clk), .reset_n(reset_n), .ena(ena), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss), .ld_pm(ld_pm),
        .alarm_en(alarm_en), .al_hh(al_hh), .al_mm(al_mm), .al_ss(al_ss), .al_pm(al_pm),
        .hh(hh_b), .mm(mm_b), .ss(ss_b), .pm(pm_b),
        .sec_tick(tick_b), .alarm_hit(hit_b), .ld_err(err_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int txn   = 0;

    // Reference model: index 0 = 12h clock, 1 = 24h clock.
    int         mt[2];      // time as seconds since midnight
    int         mcnt[2];    // ena pulses seen toward the next second
    logic [2:0] mflags[2];  // {sec_tick, alarm_hit, ld_err}

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] v);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9)
            return -1;
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    // Displayed {hh, mm, ss, pm} for a seconds-of-day value.
    function automatic logic [24:0] disp(input int i, input int tt);
        int h24, hd;
        h24 = tt / 3600;
        if (i == 1)
            hd = h24;
        else
            hd = (h24 % 12 == 0) ? 12 : h24 % 12;
        return {to_bcd(hd), to_bcd((tt / 60) % 60), to_bcd(tt % 60), (h24 >= 12)};
    endfunction

    task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got hh:mm:ss=%h:%h:%h pm=%b tick=%b hit=%b err=%b, want %h:%h:%h pm=%b tick=%b hit=%b err=%b",
                     tag, obs[27:20], obs[19:12], obs[11:4], obs[3], obs[2], obs[1], obs[0],
                     exp[27:20], exp[19:12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mt[i]     = 0;
            mcnt[i]   = 0;
            mflags[i] = 3'b000;
        end
    endtask

    // One clock edge of the reference clock, using the inputs applied to the DUT.
    task automatic model_step(input int i);
        int h, m, s, h24;
        logic [24:0] d;
        mflags[i] = 3'b000;
        if (!reset_n) begin
            mt[i]   = 0;
            mcnt[i] = 0;
        end else if (load) begin
            h = from_bcd(ld_hh);
            m = from_bcd(ld_mm);
            s = from_bcd(ld_ss);
            if (h >= 0 && m >= 0 && s >= 0 && m < 60 && s < 60 &&
                ((i == 1) ? (h <= 23) : (h >= 1 && h <= 12))) begin
                h24     = (i == 1) ? h : (h % 12) + (ld_pm ? 12 : 0);
                mt[i]   = h24 * 3600 + m * 60 + s;
                mcnt[i] = 0;
            end else begin
                mflags[i][0] = 1'b1;
            end
        end else if (ena) begin
            if (mcnt[i] == div_of(i) - 1) begin
                mcnt[i]      = 0;
                mt[i]        = (mt[i] + 1) % 86400;
                mflags[i][2] = 1'b1;
                d = disp(i, mt[i]);
                if (alarm_en && d[24:17] == al_hh && d[16:9] == al_mm && d[8:1] == al_ss &&
                    (i == 1 || d[0] == al_pm))
                    mflags[i][1] = 1'b1;
            end else begin
                mcnt[i]++;
            end
        end
    endtask

    task automatic check_all(input string when);
        check({when, "/12h"}, {hh_a, mm_a, ss_a, pm_a, tick_a, hit_a, err_a}, {disp(0, mt[0]), mflags[0]});
        check({when, "/24h"}, {hh_b, mm_b, ss_b, pm_b, tick_b, hit_b, err_b}, {disp(1, mt[1]), mflags[1]});
    endtask

    // Apply the current inputs for one clock, update the model, check at the falling edge.
    task automatic step_cycle(input string when);
        logic was_load;
        was_load = load;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_all(when);
        if (was_load) begin
            txn++;
            $display("txn %0d load %h:%h:%h pm=%b -> 12h %h:%h:%h err=%b | 24h %h:%h:%h err=%b",
                     txn, ld_hh, ld_mm, ld_ss, ld_pm, hh_a, mm_a, ss_a, err_a, hh_b, mm_b, ss_b, err_b);
        end
        if (hit_a || hit_b)
            $display("txn alarm hit12=%b hit24=%b at 12h %h:%h:%h | 24h %h:%h:%h",
                     hit_a, hit_b, hh_a, mm_a, ss_a, hh_b, mm_b, ss_b);
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                           input logic p, input string when);
        ld_hh = h; ld_mm = m; ld_ss = s; ld_pm = p;
        load  = 1'b1;
        step_cycle(when);
        load  = 1'b0;
    endtask

    task automatic run(input int n, input logic e, input string when);
        ena = e;
        for (int k = 0; k < n; k++)
            step_cycle(when);
    endtask

    initial begin
        logic [24:0] a;
        int j, pick;
        reset_n = 1'b0; ena = 1'b1; load = 1'b0;
        ld_hh = 8'h00; ld_mm = 8'h00; ld_ss = 8'h00; ld_pm = 1'b0;
        alarm_en = 1'b0; al_hh = 8'h00; al_mm = 8'h00; al_ss = 8'h00; al_pm = 1'b0;
        model_reset();

        // Reset held with ena and load active.
        load = 1'b1;
        run(3, 1'b1, "reset");
        load = 1'b0;
        reset_n = 1'b1;
        run(10, 1'b1, "count");

        // Hour and pm roll-over cases.
        do_load(8'h11, 8'h59, 8'h58, 1'b1, "ld_115958pm");
        run(12, 1'b1, "roll_pm");
        do_load(8'h12, 8'h59, 8'h59, 1'b0, "ld_125959");
        run(6, 1'b1, "roll_12_01");
        do_load(8'h23, 8'h59, 8'h59, 1'b0, "ld_235959");
        run(3, 1'b1, "roll_24");
        do_load(8'h11, 8'h59, 8'h59, 1'b0, "ld_115959");
        run(5, 1'b1, "roll_noon");

        // Rejected loads.
        do_load(8'h10, 8'h1A, 8'h00, 1'b0, "ld_bad_mm");
        do_load(8'h00, 8'h30, 8'h00, 1'b0, "ld_hh00");
        do_load(8'h24, 8'h00, 8'h60, 1'b0, "ld_bad");
        run(3, 1'b0, "idle");

        // Alarm at 00:01:00, enabled then disabled.
        al_hh = 8'h00; al_mm = 8'h01; al_ss = 8'h00; al_pm = 1'b0;
        alarm_en = 1'b1;
        do_load(8'h00, 8'h00, 8'h58, 1'b0, "al_ld");
        run(6, 1'b1, "al_on");
        alarm_en = 1'b0;
        do_load(8'h00, 8'h00, 8'h58, 1'b0, "al_ld2");
        run(6, 1'b1, "al_off");
        alarm_en = 1'b1;
        do_load(8'h00, 8'h01, 8'h00, 1'b0, "al_ld_on_time");
        run(3, 1'b0, "al_hold");

        // Random traffic with edge-biased loads and near-future alarms.
        for (int c = 0; c < 3000; c++) begin
            ena  = ($urandom_range(0, 9) < 8);
            load = ($urandom_range(0, 39) == 0);
            if (load) begin
                if ($urandom_range(0, 3) == 0) begin
                    ld_hh = 8'($urandom); ld_mm = 8'($urandom); ld_ss = 8'($urandom);
                end else if ($urandom_range(0, 1) == 0) begin
                    pick  = $urandom_range(0, 4);
                    ld_hh = to_bcd(pick == 0 ? 11 : pick == 1 ? 12 : pick == 2 ? 23 : pick == 3 ? 0 : $urandom_range(0, 23));
                    ld_mm = 8'h59;
                    ld_ss = to_bcd($urandom_range(50, 59));
                end else begin
                    ld_hh = to_bcd($urandom_range(0, 23));
                    ld_mm = to_bcd($urandom_range(0, 59));
                    ld_ss = to_bcd($urandom_range(0, 59));
                end
                ld_pm = 1'($urandom);
            end
            if ($urandom_range(0, 99) == 0) begin
                j = $urandom_range(0, 1);
                a = disp(j, (mt[j] + $urandom_range(1, 20)) % 86400);
                al_hh = a[24:17]; al_mm = a[16:9]; al_ss = a[8:1]; al_pm = a[0];
                alarm_en = ($urandom_range(0, 3) != 0);
            end
            step_cycle("rand");
            load = 1'b0;
        end

        // Asynchronous reset between clock edges.
        ena = 1'b1;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        @(negedge clk);
        load = 1'b1;
        run(2, 1'b1, "rst_hold");
        load = 1'b0;
        reset_n = 1'b1;
        run(6, 1'b1, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_clock_ext.md
Name: bcd_clock_ext

Overview:
Parametrised successor to the 12-hour BCD wall clock. It adds a compile-time 12h/24h mode, an enable prescaler (several ena pulses per second), a synchronous time-set port with range checking, and a one-shot alarm comparator. It sits between the system tick generator, which drives ena, and the display/alarm logic.

Parameters:
MODE24, 0, 0 = 12-hour display (12,01..11 plus pm); 1 = 24-hour display (00..23), pm derived from the hour.
TICK_DIV, 1, number of ena pulses per one-second advance; legal range 1..1024.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
ena  in  1  tick strobe from the prescaler source
load  in  1  synchronous time-set request
ld_hh  in  8  BCD hours to load
ld_mm  in  8  BCD minutes to load
ld_ss  in  8  BCD seconds to load
ld_pm  in  1  pm flag to load; ignored when MODE24=1
alarm_en  in  1  alarm compare enable
al_hh  in  8  BCD alarm hours
al_mm  in  8  BCD alarm minutes
al_ss  in  8  BCD alarm seconds
al_pm  in  1  alarm pm flag; ignored when MODE24=1
hh  out  8  BCD hours
mm  out  8  BCD minutes
ss  out  8  BCD seconds
pm  out  1  PM indicator
sec_tick  out  1  one-cycle pulse on every second advance
alarm_hit  out  1  one-cycle alarm pulse
ld_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (reset_n=0, asynchronous) sets the following, and holds them while reset_n is low:
  - MODE24=0: hh=8'h12, mm=8'h00, ss=8'h00, pm=0.
  - MODE24=1: hh=8'h00, mm=8'h00, ss=8'h00, pm=0.
  - Prescaler count=0; sec_tick, alarm_hit and ld_err all 0.
- Priority per clock: reset > load > ena. Reset wins regardless of ena or load.
- Prescaler: width $clog2(TICK_DIV) (minimum 1 bit).
  - On ena: if count==TICK_DIV-1, advance one second and set count=0; otherwise count+1.
  - With ena low, the count holds.
- Second advance, all BCD:
  - ss counts 00..59; wrapping 59->00 carries into mm.
  - mm counts 00..59; wrapping 59->00 carries into hh.
- Hours, MODE24=0:
  - Sequence 12,01,02..11,12.
  - pm toggles exactly on the 11:59:59 -> 12:00:00 transition.
  - 12:59:59 -> 01:00:00 does not toggle pm.
- Hours, MODE24=1:
  - Sequence 00..23, then wraps to 00.
  - pm = (hh >= 12) at all times, including after reset and load.
- Every digit nibble is a legal BCD value (<= 9) at every cycle. The counters never pass through non-BCD values.
- sec_tick: registered; high for exactly the cycle in which the advanced time first appears on the outputs.
- Load:
  - Accepted only if all of the following hold:
    - every nibble is <= 9;
    - ld_mm <= 8'h59 and ld_ss <= 8'h59;
    - hh is in 8'h01..8'h12 (MODE24=0) or 8'h00..8'h23 (MODE24=1).
  - Accepted load: the time registers take the loaded values on that edge and the prescaler count clears to 0. ena is ignored that cycle (no advance, no count).
  - Rejected load: time and prescaler are unchanged. ld_err=1 for one cycle, and ena is also ignored that cycle.
- Alarm:
  - The compare uses the next-state time of a second advance only. Both pm fields are compared in 12h mode; the pm fields are ignored in 24h mode.
  - alarm_hit=1 in the same cycle the matching time appears, provided alarm_en was 1 at the advancing edge.
  - A load that lands on the alarm time does not fire. Holding at the alarm time does not re-fire.
- Reset mid-operation clears all pulses immediately. Deasserting reset_n does not advance the clock on that edge.

Decomposition:
- Package bcd_clock_pkg:
  - constants BCD_59=8'h59, BCD_12=8'h12, BCD_23=8'h23;
  - function bcd_valid(8b) and function bcd_inc(8b), returning value + carry.
- Sub-module bcd_mod60, instantiated twice (ss, mm):
  - ports clk, reset_n, clr, ld, ld_val, inc, q, wrap;
  - wrap is combinational: q==59 && inc.
- Hours, pm, prescaler, load checking and alarm logic stay in the top.

Test Plan:
- Reset then ena=1 (TICK_DIV=1, MODE24=0): outputs 12:00:00 AM. After 10 clocks ss=8'h10 and sec_tick pulses every cycle.
- Load 12'h...:11:59:58 pm=1 (MODE24=0), then 2 ena -> 11:59:59 PM, then 12:00:00 AM. Next, load 12:59:59 AM and 1 ena -> 01:00:00 AM, pm stays 0.
- MODE24=1: load 23:59:59 and 1 ena -> 00:00:00, pm=0. Load 11:59:59 and 1 ena -> 12:00:00, pm=1.
- TICK_DIV=4: ena held high -> ss increments every 4th cycle. Drop ena for 3 cycles mid-count -> count holds and the advance is delayed 3 cycles. Load clears the prescaler.
- Load ld_mm=8'h1A -> ld_err pulses, time unchanged. Load ld_hh=8'h00 in 12h mode -> rejected. Load with ena=1 -> no advance that cycle.
- Alarm 00:01:00 AM, alarm_en=1, start from 12:00:58? Use MODE24=1: alarm 00:01:00, load 00:00:58 -> alarm_hit exactly once, on the cycle mm=8'h01 and ss=8'h00. Repeat with alarm_en=0 -> no pulse. Assert reset_n mid-count -> async clear to 00:00:00.
